req_hold_checker: RTL
=====================

Name: req_hold_checker

Overview:
- Synthesizable, multi-channel successor to the single-signal "req |=> !req" property check.
- Monitors NUM_CH request lines and flags any request held high longer than MAX_HOLD consecutive cycles.
- Reports violations through sticky registers, a saturating counter and an interrupt instead of simulation-only system tasks.
- Sits beside bus/handshake logic as an always-on protocol watchdog, readable by firmware.

Parameters:
- NUM_CH, 4: number of monitored request channels (1..32).
- MAX_HOLD, 1: maximum legal consecutive high samples of a req (1..255); 1 reproduces "req |=> !req".
- CNT_W, 8: width of the global violation counter.

Ports:
- clk  input  1  single clock; all sampling on posedge.
- rst_n  input  1  asynchronous, active-low reset.
- enable  input  1  checking enable; 0 idles all channel FSMs.
- req  input  NUM_CH  monitored request lines, one bit per channel.
- clr_err  input  1  synchronous clear of err_flag, err_cnt, first_err_*, irq.
- err_flag  output  NUM_CH  sticky per-channel violation flags.
- err_cnt  output  CNT_W  saturating count of violation events.
- first_err_vld  output  1  first_err_ch holds a valid capture.
- first_err_ch  output  $clog2(NUM_CH) (min 1)  index of the first violating channel since reset/clear.
- irq  output  1  level interrupt; high while any err_flag bit is set.

Behaviour:
- Reset (rst_n=0, async): all outputs 0, all channel FSMs IDLE, hold counters 0.
- Per-channel FSM, 8-bit hold counter hcnt, evaluated at each posedge with enable=1:
  - IDLE: if req=1, hcnt<=1 and go HIGH; else stay.
  - HIGH: if req=0, go IDLE, hcnt<=0.
  - HIGH: if req=1 and hcnt<MAX_HOLD, hcnt<=hcnt+1.
  - HIGH: if req=1 and hcnt==MAX_HOLD, raise a violation pulse and go VIOL.
  - VIOL: if req=0, go IDLE; else stay. No further violations until req drops, so one event per contiguous high run.
- Violation latency: err_flag[i] is set at the edge where the violation is detected.
  - Example, MAX_HOLD=1: req high at edges 0 and 1 -> err_flag visible after edge 1.
- err_cnt: increments by the popcount of violation pulses in that cycle; saturates at 2^CNT_W-1 and never wraps.
- first_err_ch/first_err_vld:
  - Captured only while first_err_vld=0.
  - Simultaneous violations: the lowest channel index wins.
  - Held until clr_err.
- irq: registered OR of err_flag; rises in the same cycle err_flag rises.
- clr_err with a violation in the same cycle:
  - Clear is applied first, then the new violation is recorded.
  - Result: that channel's flag=1, err_cnt equals that cycle's popcount, first_err recaptured.
- enable=0:
  - FSMs forced IDLE and hcnt=0; no violations raised.
  - Flags, counter and capture hold their values; clr_err still works.
  - Re-enable with req already high counts from 1 at the first enabled edge.
- Reset mid-run: async clear of everything; the next run starts from IDLE.
- req is assumed synchronous to clk; no internal synchronizers.

Optional Feature:
- Macro: REQ_HOLD_CHECKER_PASS_CNT_EN.
- Defined:
  - Adds output pass_cnt (NUM_CH*CNT_W), one saturating counter per channel.
  - A counter increments when a HIGH run ends legally (HIGH->IDLE).
  - Runs ending from VIOL are not counted.
  - Cleared by reset and by clr_err.
- Undefined: the port and its logic are absent; all other behaviour is identical.

Test Plan:
- MAX_HOLD=1, NUM_CH=4: req[2] pulses 1 cycle -> no flag; then high for 2 edges -> err_flag=4'b0100, err_cnt=1, first_err_ch=2, irq=1.
- req[1] and req[3] violate in the same cycle -> err_flag=4'b1010, err_cnt+=2, first_err_ch=1.
- MAX_HOLD=3: req[0] high for 10 cycles -> exactly one violation, at the 4th edge; err_cnt=1.
- CNT_W=2: 5 separate violations -> err_cnt stays 3.
- clr_err asserted in the same cycle req[0] violates -> err_flag=4'b0001, err_cnt=1, first_err_ch=0.
- enable=0 while req[0] held 5 cycles -> no flags. rst_n pulsed mid-run -> all outputs 0 immediately (async).
- With REQ_HOLD_CHECKER_PASS_CNT_EN: 3 legal pulses on ch0 -> pass_cnt[ch0]=3.

Source files
------------

// File: rtl/req_hold_checker.sv
// req_hold_checker: multi-channel request hold-time watchdog.
// Optional per-channel pass counters: define REQ_HOLD_CHECKER_PASS_CNT_EN.
module req_hold_checker #(
  parameter  int NUM_CH   = 4,
  parameter  int MAX_HOLD = 1,
  parameter  int CNT_W    = 8,
  localparam int CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable,
  input  logic [NUM_CH-1:0] req,
  input  logic              clr_err,
  output logic [NUM_CH-1:0] err_flag,
  output logic [CNT_W-1:0]  err_cnt,
  output logic              first_err_vld,
  output logic [CH_W-1:0]   first_err_ch,
`ifdef REQ_HOLD_CHECKER_PASS_CNT_EN
  output logic [NUM_CH*CNT_W-1:0] pass_cnt,
`endif
  output logic              irq
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    VIOL = 2'd2
  } st_e;

  localparam int SW = CNT_W + 8;
  localparam logic [7:0] MAXH = 8'(MAX_HOLD);
  localparam logic [SW-1:0] CNT_MAX = {{8{1'b0}}, {CNT_W{1'b1}}};

  st_e         st   [NUM_CH];
  logic [7:0]  hcnt [NUM_CH];

  logic [NUM_CH-1:0] viol;
  logic [6:0]        pop;
  logic [CNT_W-1:0]  cnt_base;
  logic [SW-1:0]     cnt_sum;
  logic [CNT_W-1:0]  cnt_nxt;
  logic [NUM_CH-1:0] flag_nxt;
  logic [CH_W-1:0]   low_idx;
  logic              vld_base;
  logic              vld_nxt;
  logic [CH_W-1:0]   ch_nxt;

  // A violation is the cycle a HIGH run reaches its limit and stays high.
  always_comb begin
    viol = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      viol[i] = enable && req[i] && (st[i] == HIGH) && (hcnt[i] == MAXH);
    end
  end

  // Clear is applied first, then this cycle's violations are merged in.
  always_comb begin
    pop = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      pop = pop + 7'(viol[i]);
    end
    cnt_base = clr_err ? '0 : err_cnt;
    cnt_sum  = SW'(cnt_base) + SW'(pop);
    cnt_nxt  = (cnt_sum > CNT_MAX) ? {CNT_W{1'b1}} : cnt_sum[CNT_W-1:0];
    flag_nxt = (clr_err ? '0 : err_flag) | viol;
    low_idx  = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (viol[i]) low_idx = CH_W'(i);
    end
    vld_base = !clr_err && first_err_vld;
    vld_nxt  = vld_base;
    ch_nxt   = clr_err ? '0 : first_err_ch;
    if (!vld_base && (|viol)) begin
      vld_nxt = 1'b1;
      ch_nxt  = low_idx;
    end
  end

  // Per-channel hold-time FSMs; disabled checking parks them in IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_CH; i++) begin
        st[i]   <= IDLE;
        hcnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (!enable) begin
          st[i]   <= IDLE;
          hcnt[i] <= '0;
        end else begin
          case (st[i])
            IDLE: begin
              if (req[i]) begin
                st[i]   <= HIGH;
                hcnt[i] <= 8'd1;
              end
            end
            HIGH: begin
              if (!req[i]) begin
                st[i]   <= IDLE;
                hcnt[i] <= '0;
              end else if (hcnt[i] < MAXH) begin
                hcnt[i] <= hcnt[i] + 8'd1;
              end else begin
                st[i] <= VIOL;
              end
            end
            VIOL: begin
              if (!req[i]) begin
                st[i]   <= IDLE;
                hcnt[i] <= '0;
              end
            end
            default: begin
              st[i]   <= IDLE;
              hcnt[i] <= '0;
            end
          endcase
        end
      end
    end
  end

  // Sticky error reporting registers and level interrupt.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_flag      <= '0;
      err_cnt       <= '0;
      first_err_vld <= 1'b0;
      first_err_ch  <= '0;
      irq           <= 1'b0;
    end else begin
      err_flag      <= flag_nxt;
      err_cnt       <= cnt_nxt;
      first_err_vld <= vld_nxt;
      first_err_ch  <= ch_nxt;
      irq           <= |flag_nxt;
    end
  end

`ifdef REQ_HOLD_CHECKER_PASS_CNT_EN
  logic [NUM_CH*CNT_W-1:0] pass_nxt;

  // A run that drops from HIGH ended within the legal hold time.
  always_comb begin
    pass_nxt = clr_err ? '0 : pass_cnt;
    for (int i = 0; i < NUM_CH; i++) begin
      if (enable && (st[i] == HIGH) && !req[i] &&
          (pass_nxt[i*CNT_W +: CNT_W] != {CNT_W{1'b1}})) begin
        pass_nxt[i*CNT_W +: CNT_W] = pass_nxt[i*CNT_W +: CNT_W] + 1'b1;
      end
    end
  end

  // Per-channel legal-run counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pass_cnt <= '0;
    else        pass_cnt <= pass_nxt;
  end
`endif

endmodule
